// File: rtl/gateway_rc_responder.sv
// rtl/gateway_rc_responder.sv - RC-side gateway transfer responder; optional address window check via GATEWAY_RESP_ADDR_CHECK_EN
module gateway_rc_responder #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF,
    parameter logic [ADDR_W-1:0] ADDR_BASE      = 32'h0040_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE      = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_transfer_valid,
    input  logic              read_transfer_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              write_resp_valid,
    output logic              read_resp_valid,
    output logic              fab_req,
    output logic              fab_we,
    output logic [ADDR_W-1:0] fab_addr,
    output logic [DATA_W-1:0] fab_wdata,
    input  logic              fab_ack,
    input  logic [DATA_W-1:0] fab_rdata,
    output logic              err_timeout,
    output logic              err_overrun,
    input  logic              err_clr
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef GATEWAY_RESP_ADDR_CHECK_EN
    localparam bit ADDR_CHECK_EN = 1'b1;
`else
    localparam bit ADDR_CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data_out;
    logic              r_wr_resp;
    logic              r_rd_resp;
    logic              r_err_to;
    logic              r_err_ovr;

    logic              w_any_valid;
    logic [ADDR_W-1:0] w_offset;
    logic              w_in_window;
    logic              w_addr_ok;
    logic              w_accept;
    logic              w_timeout;
    logic              w_cmpl;
    logic              w_cmpl_we;
    logic              w_overrun;

    // Offset form of the window test stays correct even if BASE+SIZE wraps the address space
    assign w_offset    = address - ADDR_BASE;
    assign w_in_window = (address >= ADDR_BASE) && (w_offset < ADDR_SIZE);
    assign w_addr_ok   = !ADDR_CHECK_EN || w_in_window;

    assign w_any_valid = write_transfer_valid || read_transfer_valid;
    assign w_accept    = (r_state == S_IDLE) && w_any_valid;
    assign w_timeout   = (r_state == S_REQ) && !fab_ack && (r_cnt == CNT_LAST);
    // A transfer completes either by rejection straight from IDLE or by ack/timeout in REQ
    assign w_cmpl      = (w_accept && !w_addr_ok) ||
                         ((r_state == S_REQ) && (fab_ack || w_timeout));
    assign w_cmpl_we   = (r_state == S_IDLE) ? write_transfer_valid : r_we;
    assign w_overrun   = ((r_state != S_IDLE) && w_any_valid) ||
                         ((r_state == S_IDLE) && write_transfer_valid && read_transfer_valid);

    // State register; asynchronous reset aborts any transfer without a response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> REQ (or RESP on reject) -> RESP -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any_valid) w_next = w_addr_ok ? S_REQ : S_RESP;
            S_REQ:  if (fab_ack || w_timeout) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Transfer latch, timeout counter, response pulses, read data and sticky error flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_wr_resp  <= 1'b0;
            r_rd_resp  <= 1'b0;
            r_err_to   <= 1'b0;
            r_err_ovr  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we   <= write_transfer_valid;
                r_addr <= address;
                r_cnt  <= '0;
                if (write_transfer_valid) begin
                    r_wdata <= data_in;
                end
            end else if (r_state == S_REQ) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_wr_resp <= w_cmpl && w_cmpl_we;
            r_rd_resp <= w_cmpl && !w_cmpl_we;
            if (w_cmpl && !w_cmpl_we) begin
                r_data_out <= ((r_state == S_REQ) && fab_ack) ? fab_rdata : ERR_DATA;
            end
            // A new error in the same cycle as err_clr keeps the flag set
            r_err_to  <= w_timeout || (r_err_to && !err_clr);
            r_err_ovr <= w_overrun || (r_err_ovr && !err_clr);
        end
    end

    assign fab_req          = (r_state == S_REQ);
    assign fab_we           = r_we;
    assign fab_addr         = r_addr;
    assign fab_wdata        = r_wdata;
    assign data_out         = r_data_out;
    assign write_resp_valid = r_wr_resp;
    assign read_resp_valid  = r_rd_resp;
    assign err_timeout      = r_err_to;
    assign err_overrun      = r_err_ovr;

endmodule
